// File: rtl/dispatch_queue_ctrl.sv
// Dispatch RAM ring-buffer controller with a 2-entry output buffer that hides the RAM read latency.
// Optional debug reporting is compiled in with `define DISPATCH_QUEUE_REPORT_EN.
module dispatch_queue_ctrl #(
    parameter int CORE        = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   ram_write,
    output logic [INDEX_WIDTH-1:0] ram_in_address,
    output logic [DATA_WIDTH-1:0]  ram_in_data,
    output logic                   ram_read,
    output logic [INDEX_WIDTH-1:0] ram_out_address,
    input  logic [DATA_WIDTH-1:0]  ram_out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [INDEX_WIDTH+1:0] count,
    input  logic                   report
);

    localparam logic [INDEX_WIDTH:0] FULL_OCC = {1'b1, {INDEX_WIDTH{1'b0}}};
    localparam logic [INDEX_WIDTH:0] PTR_ONE  = {{INDEX_WIDTH{1'b0}}, 1'b1};

    logic [INDEX_WIDTH:0]  wr_ptr;
    logic [INDEX_WIDTH:0]  rd_ptr;
    logic [INDEX_WIDTH:0]  occupancy;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic                  accept;
    logic                  issue;
    logic                  out_fire;
    logic                  push;

    always_comb begin
        occupancy = wr_ptr - rd_ptr;
        in_ready  = !flush && (occupancy != FULL_OCC);
        // Gating with reset keeps the RAM untouched while reset is held.
        accept    = in_valid && in_ready && reset;
        out_valid = (buf_cnt != 2'd0);
        out_fire  = out_valid && out_ready;
        push      = inflight;
        // Issue only when the buffer will still have room once the read returns.
        issue     = !flush && reset && (occupancy != '0) &&
                    (({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, out_fire}));
    end

    assign ram_write       = accept;
    assign ram_in_address  = wr_ptr[INDEX_WIDTH-1:0];
    assign ram_in_data     = in_data;
    assign ram_read        = issue;
    assign ram_out_address = rd_ptr[INDEX_WIDTH-1:0];
    assign out_data        = buf_head;
    assign count           = {1'b0, occupancy}
                           + {{(INDEX_WIDTH+1){1'b0}}, inflight}
                           + {{INDEX_WIDTH{1'b0}}, buf_cnt};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            buf_head <= '0;
            buf_tail <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (issue)
                rd_ptr <= rd_ptr + PTR_ONE;
            inflight <= issue;

            case ({push, out_fire})
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf_head <= ram_out_data;
                    else
                        buf_tail <= ram_out_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= ram_out_data;
                    end else begin
                        buf_head <= ram_out_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DISPATCH_QUEUE_REPORT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset && report)
            $display("core%0d cyc=%0d wr=%0d rd=%0d buf=%0d infl=%0b cnt=%0d in_v=%0b in_r=%0b out_v=%0b out_r=%0b out_data=%h",
                     CORE, cycle_cnt, wr_ptr, rd_ptr, buf_cnt, inflight, count,
                     in_valid, in_ready, out_valid, out_ready, out_data);
    end
`else
    localparam int core_unused = CORE;
    logic report_unused;
    assign report_unused = report;
`endif

endmodule

// File: tb/tb_dispatch_queue_ctrl.sv
// Self-checking bench for dispatch_queue_ctrl: directed scenarios plus randomized traffic
// scored against a word-queue model of the controller contents.
module tb_dispatch_queue_ctrl;

    localparam int DW    = 32;
    localparam int IW    = 3;
    localparam int DEPTH = 1 << IW;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          ram_write;
    logic [IW-1:0] ram_in_address;
    logic [DW-1:0] ram_in_data;
    logic          ram_read;
    logic [IW-1:0] ram_out_address;
    logic [DW-1:0] ram_out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW+1:0] count;
    logic          report;

    int unsigned   total = 0;
    int unsigned   bad   = 0;

    // Reference: words accepted and not yet consumed, in order.
    logic [DW-1:0] model_q[$];
    int unsigned   wr_n = 0;
    int unsigned   rd_n = 0;
    logic [DW-1:0] ram [DEPTH];

    always #5 clock = ~clock;

    dispatch_queue_ctrl #(
        .CORE        (0),
        .DATA_WIDTH  (DW),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .ram_write       (ram_write),
        .ram_in_address  (ram_in_address),
        .ram_in_data     (ram_in_data),
        .ram_read        (ram_read),
        .ram_out_address (ram_out_address),
        .ram_out_data    (ram_out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .count           (count),
        .report          (report)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Dispatch RAM with one cycle of read latency.
    initial ram_out_data = '0;
    always @(posedge clock) begin
        if (ram_write)
            ram[ram_in_address] <= ram_in_data;
        if (ram_read)
            ram_out_data <= ram[ram_out_address];
    end

    // Per-cycle scoreboard, sampled mid-cycle before the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("rst_write", ram_write, 0);
            check("rst_valid", out_valid, 0);
            check("rst_count", count, 0);
            model_q.delete();
            wr_n = 0;
            rd_n = 0;
        end else begin
            check("count", count, model_q.size());
            if (model_q.size() == 0)
                check("valid_empty", out_valid, 0);
            if (!flush && model_q.size() < DEPTH)
                check("in_ready_room", in_ready, 1);
            if (model_q.size() == DEPTH + 2)
                check("in_ready_full", in_ready, 0);
            if (ram_write) begin
                check("wr_addr", ram_in_address, wr_n % DEPTH);
                check("wr_data", ram_in_data, in_data);
            end
            if (ram_read) begin
                check("rd_addr", ram_out_address, rd_n % DEPTH);
                check("rd_ahead", rd_n < wr_n, 1);
            end
            if (out_valid && out_ready && model_q.size() != 0)
                check("out_data", out_data, model_q[0]);
            if (flush) begin
                check("flush_write", ram_write, 0);
                check("flush_read", ram_read, 0);
                model_q.delete();
                wr_n = 0;
                rd_n = 0;
            end else begin
                if (out_valid && out_ready && model_q.size() != 0)
                    void'(model_q.pop_front());
                if (in_valid && in_ready) begin
                    model_q.push_back(in_data);
                    wr_n++;
                end
                if (ram_read)
                    rd_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        int unsigned n_out;
        logic        got;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h5555_0000;
        out_ready = 1'b0; report = 1'b0;

        repeat (3) begin
            next_cycle();
            #2;
            check("rst_in_ready", in_ready, 1);
            check("rst_read", ram_read, 0);
            check("rst_wr_strobe", ram_write, 0);
            check("rst_cnt", count, 0);
        end

        next_cycle();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // Single word latency.
        next_cycle();
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        #2;
        check("sw_write", ram_write, 1);
        check("sw_waddr", ram_in_address, 0);
        next_cycle();
        in_valid = 1'b0;
        #2;
        check("sw_read", ram_read, 1);
        check("sw_raddr", ram_out_address, 0);
        check("sw_valid_t1", out_valid, 0);
        next_cycle();
        #2;
        check("sw_valid_t2", out_valid, 0);
        next_cycle();
        #2;
        check("sw_valid_t3", out_valid, 1);
        check("sw_data", out_data, 32'hDEAD_BEEF);
        next_cycle();
        #2;
        check("sw_count", count, 0);

        // Fill with the core stalled, then drain.
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            next_cycle();
            in_valid = 1'b1;
            in_data  = 32'h100 + acc;
            #2;
            if (in_ready)
                acc++;
        end
        check("fill_acc", acc, DEPTH + 2);
        check("fill_in_ready", in_ready, 0);
        check("fill_count", count, DEPTH + 2);
        for (int k = 0; k < DEPTH + 2; k++) begin
            next_cycle();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #2;
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, 32'h100 + k);
        end
        next_cycle();
        #2;
        check("drain_in_ready", in_ready, 1);
        check("drain_count", count, 0);

        // Streaming with both sides ready, wrapping the RAM addresses.
        n_out = 0;
        for (int k = 0; k < 26; k++) begin
            next_cycle();
            in_valid = (k < 20);
            in_data  = 32'h200 + k;
            #2;
            if (k < 20)
                check("wrap_ready", in_ready, 1);
            if (out_valid) begin
                check("wrap_data", out_data, 32'h200 + n_out);
                n_out++;
            end else if (n_out > 0 && n_out < 20) begin
                check("wrap_gap", out_valid, 1);
            end
        end
        check("wrap_n", n_out, 20);

        // Flush with a full buffer and a read that would otherwise issue.
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            in_valid = 1'b1;
            in_data  = 32'h300 + k;
        end
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        #2;
        check("flush_noread", ram_read, 0);
        check("flush_in_ready", in_ready, 0);
        next_cycle();
        flush = 1'b0;
        #2;
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        next_cycle();
        in_valid = 1'b1; in_data = 32'h0000_4444;
        #2;
        check("post_flush_write", ram_write, 1);
        check("post_flush_addr", ram_in_address, 0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            next_cycle();
            in_valid = 1'b0;
            #2;
            if (out_valid) begin
                got = 1'b1;
                check("post_flush_data", out_data, 32'h0000_4444);
            end
        end
        check("post_flush_seen", got, 1);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            in_valid = 1'b1;
            in_data  = 32'h500 + k;
        end
        check("pre_areset_valid", out_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_count", count, 0);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        reset = 1'b1;
        repeat (4) next_cycle();
        #2;
        check("post_areset_valid", out_valid, 0);
        check("post_areset_count", count, 0);

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 600; k++) begin
            next_cycle();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            out_ready = (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
        end

        next_cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (16) next_cycle();
        #2;
        check("final_count", count, 0);
        check("final_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_queue_ctrl.md
# dispatch_queue_ctrl

Ring-buffer controller that sits directly around the per-core dispatch RAM interface. It drives both the write and read sides of that RAM. It accepts dispatch words from the upstream scheduler over a valid/ready handshake, stores them at rolling addresses, and streams them in FIFO order to the core through a 2-entry output buffer. The buffer hides the RAM's 1-cycle read latency and sustains one word per cycle.

## Interface
- CORE, 0, core index used in report output
- DATA_WIDTH, 32, dispatch word width
- INDEX_WIDTH, 3, RAM address width; DEPTH = 2^INDEX_WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous discard of all queued and in-flight words
- in_valid  in  1  upstream word valid
- in_ready  out  1  controller can accept a word
- in_data  in  DATA_WIDTH  upstream word
- ram_write  out  1  write strobe to dispatch RAM
- ram_in_address  out  INDEX_WIDTH  write address
- ram_in_data  out  DATA_WIDTH  write data (equals in_data)
- ram_read  out  1  read strobe to dispatch RAM
- ram_out_address  out  INDEX_WIDTH  read address
- ram_out_data  in  DATA_WIDTH  read data, valid the cycle after ram_read
- out_valid  out  1  output word valid
- out_ready  in  1  core accepts output word
- out_data  out  DATA_WIDTH  output word (head of buffer)
- count  out  INDEX_WIDTH+2  words held: RAM-resident + in-flight + buffered
- report  in  1  debug print request

## Operation
- Pointers wr_ptr and rd_ptr are each INDEX_WIDTH+1 bits. RAM occupancy is wr_ptr−rd_ptr, mod 2^(INDEX_WIDTH+1).
- The low INDEX_WIDTH bits of each pointer drive the RAM address, so addresses wrap from DEPTH−1 to 0.
- in_ready = !flush && occupancy != DEPTH. It depends on registers only (plus flush), never on out_ready.
- Accept (in_valid && in_ready): ram_write=1, ram_in_address=wr_ptr[low], and wr_ptr increments.
- Read issue: when occupancy>0 and buf_cnt + inflight − out_fire < 2: ram_read=1, ram_out_address=rd_ptr[low], rd_ptr increments, and inflight is set for the next cycle.
  - out_fire = out_valid && out_ready.
- A RAM entry is readable at the earliest in the cycle after its write, because occupancy is registered.
- Returning data (inflight=1) is appended to the 2-entry buffer. out_data is the buffer head. out_valid = buf_cnt>0.
- count = occupancy + inflight + buf_cnt. Maximum is DEPTH+2.
- flush has highest priority. In the flush cycle:
  - no accept, no read issue.
  - At the next edge: pointers=0, buf_cnt=0, inflight=0.
  - Data returning from a pre-flush read is discarded.
- Simultaneous accept and read in the same cycle are both performed. Simultaneous buffer push and pop keep buf_cnt unchanged.
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, ram_write=0, ram_read=0, both addresses=0.

## Timing
- Input accepted in cycle t:
  - ram_write in cycle t.
  - Earliest ram_read in t+1.
  - ram_out_data in t+2.
  - out_valid=1 in t+3 (3-cycle latency when empty).
- Steady state with both sides always ready: one word in and one word out per cycle. in_ready never drops.
- With out_ready held low, the controller absorbs DEPTH+2 words before in_ready=0.
- Reset is asynchronous on assertion. All state clears immediately, including mid-read; data returning after release is discarded.

## Configuration
- DISPATCH_QUEUE_REPORT_EN defined:
  - On each edge with report=1, $display prints CORE, cycle count, wr_ptr, rd_ptr, buf_cnt, inflight, count, in/out handshake signals and out_data.
  - The cycle counter clears on reset.
- Not defined: report is ignored, and no counter or display logic is compiled. Functional behaviour is identical in both cases.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 → in_ready=1, out_valid=0, count=0, ram_write=0, ram_read=0. No write occurs while reset=0.
- Single word: push 0xDEADBEEF at t (empty queue, out_ready=1).
  - ram_write, address 0 at t.
  - ram_read, address 0 at t+1.
  - out_valid=1, out_data=0xDEADBEEF at t+3.
  - count back to 0 after the pop.
- Fill/drain (INDEX_WIDTH=3): out_ready=0, push 0x100..0x109.
  - Exactly 10 accepted, in_ready=0, count=10.
  - Raise out_ready: 0x100..0x109 emerge in order, one per cycle, and in_ready returns to 1.
- Wrap: stream 20 words with both sides ready → addresses wrap 7→0. Output is in order with no gaps after the first word.
- Flush mid-stream: flush in a cycle with ram_read pending and buf_cnt=2.
  - Next cycle: count=0, out_valid=0.
  - Stale return data is never presented.
  - Next push is written to address 0.
- Async reset mid-stream: drive reset=0 between edges → out_valid and count go to 0 immediately, without a clock edge.
